core_issue_ctrl: RTL and testbench

- Backend-side responder to the frontend's dual-slot instruction interface.
- Each cycle it examines the two presented instructions (slot0 older), checks register hazards against a 32-entry pending-write scoreboard, pipe conflicts and serialization, and returns the combinational issue[1:0] handshake.
- The frontend uses issue[1:0] in the same cycle to advance its issue register.
- Sits between the frontend output and the backend dispatch/execute stages.

---
 rtl/core_issue_ctrl.sv | 106 ++++++++++
 tb/tb_core_issue_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/core_issue_ctrl.sv
// Dual-slot issue controller: scoreboard-based hazard checks, pipe conflicts and
// serialization produce the combinational issue handshake back to the frontend.
module core_issue_ctrl #(
    parameter int WB_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               inst_valid_i,
    input  logic [1:0][4:0]          r0_reg_i,
    input  logic [1:0][4:0]          r1_reg_i,
    input  logic [1:0][4:0]          w_reg_i,
    input  logic [1:0][1:0]          pipe_i,
    input  logic [1:0]               serial_i,
    input  logic                     backend_stall_i,
    input  logic                     flush_i,
    input  logic [WB_PORTS-1:0]      wb_valid_i,
    input  logic [WB_PORTS-1:0][4:0] wb_reg_i,
    input  logic                     serial_done_i,
    output logic [1:0]               issue_o,
    output logic                     busy_o
);

    localparam logic [1:0] PIPE_ALU = 2'd0;

    // Handshake: issue_o[s] means the frontend may retire slot s this cycle; slot1 only with slot0.
    typedef enum logic {
        NORMAL = 1'b0,
        SERIAL = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] sb;
    logic [31:0] clr_mask;
    logic [31:0] set_mask;
    logic [31:0] pend;
    logic [1:0]  slot_ok;
    logic        can_issue;
    logic        intra_hazard;
    logic        pipe_conflict;

    // Pending view after this cycle's writebacks, so a same-cycle writeback bypasses.
    always_comb begin
        clr_mask = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid_i[p]) clr_mask[wb_reg_i[p]] = 1'b1;
        end
    end

    assign pend = sb & ~clr_mask;

    always_comb begin
        slot_ok = '0;
        for (int s = 0; s < 2; s++) begin
            slot_ok[s] = inst_valid_i[s] && !pend[r0_reg_i[s]] &&
                         !pend[r1_reg_i[s]] && !pend[w_reg_i[s]];
        end
    end

    assign can_issue     = rst_n && (state == NORMAL) && !backend_stall_i && !flush_i;
    assign intra_hazard  = (w_reg_i[0] != 5'd0) &&
                           ((w_reg_i[0] == r0_reg_i[1]) || (w_reg_i[0] == r1_reg_i[1]) ||
                            (w_reg_i[0] == w_reg_i[1]));
    assign pipe_conflict = (pipe_i[0] == pipe_i[1]) && (pipe_i[0] != PIPE_ALU);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= NORMAL;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: if (issue_o[0] && serial_i[0]) state_nxt = SERIAL;
            SERIAL: if (serial_done_i || flush_i) state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    // Output logic
    always_comb begin
        issue_o    = 2'b00;
        issue_o[0] = can_issue && slot_ok[0] && (!serial_i[0] || (pend == '0));
        issue_o[1] = issue_o[0] && slot_ok[1] && !intra_hazard && !pipe_conflict &&
                     !serial_i[0] && !serial_i[1];
    end

    always_comb begin
        set_mask = '0;
        for (int s = 0; s < 2; s++) begin
            if (issue_o[s]) set_mask[w_reg_i[s]] = 1'b1;
        end
        set_mask[0] = 1'b0;
    end

    // Set wins over clear; flush kills every outstanding write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sb <= '0;
        else if (flush_i) sb <= '0;
        else              sb <= pend | set_mask;
    end

    assign busy_o = (sb != '0) || (state == SERIAL);

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl: expected issue values queued at drive time,
// popped and compared mid-cycle, with busy checked alongside.
module tb_core_issue_ctrl;

    localparam int WB_PORTS = 2;

    logic                     clk;
    logic                     rst_n;
    logic [1:0]               inst_valid_i;
    logic [1:0][4:0]          r0_reg_i;
    logic [1:0][4:0]          r1_reg_i;
    logic [1:0][4:0]          w_reg_i;
    logic [1:0][1:0]          pipe_i;
    logic [1:0]               serial_i;
    logic                     backend_stall_i;
    logic                     flush_i;
    logic [WB_PORTS-1:0]      wb_valid_i;
    logic [WB_PORTS-1:0][4:0] wb_reg_i;
    logic                     serial_done_i;
    logic [1:0]               issue_o;
    logic                     busy_o;

    logic [1:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    core_issue_ctrl #(.WB_PORTS(WB_PORTS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_valid_i    (inst_valid_i),
        .r0_reg_i        (r0_reg_i),
        .r1_reg_i        (r1_reg_i),
        .w_reg_i         (w_reg_i),
        .pipe_i          (pipe_i),
        .serial_i        (serial_i),
        .backend_stall_i (backend_stall_i),
        .flush_i         (flush_i),
        .wb_valid_i      (wb_valid_i),
        .wb_reg_i        (wb_reg_i),
        .serial_done_i   (serial_done_i),
        .issue_o         (issue_o),
        .busy_o          (busy_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Driver tasks
    task automatic idle();
        inst_valid_i    = 2'b00;
        r0_reg_i        = '0;
        r1_reg_i        = '0;
        w_reg_i         = '0;
        pipe_i          = '0;
        serial_i        = 2'b00;
        backend_stall_i = 1'b0;
        flush_i         = 1'b0;
        wb_valid_i      = '0;
        wb_reg_i        = '0;
        serial_done_i   = 1'b0;
    endtask

    task automatic slot(input int s, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] w, input logic [1:0] pipe, input logic ser);
        inst_valid_i[s] = 1'b1;
        r0_reg_i[s]     = r0;
        r1_reg_i[s]     = r1;
        w_reg_i[s]      = w;
        pipe_i[s]       = pipe;
        serial_i[s]     = ser;
    endtask

    task automatic wb(input int p, input logic [4:0] r);
        wb_valid_i[p] = 1'b1;
        wb_reg_i[p]   = r;
    endtask

    // Called at posedge+1 after inputs are set; compares at posedge+4.
    task automatic step(input string tag, input logic [1:0] exp_issue, input logic exp_busy);
        exp_q.push_back(exp_issue);
        #3;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            check({tag, ".issue"}, {6'd0, issue_o}, {6'd0, exp_q.pop_front()});
        end
        check({tag, ".busy"}, {7'd0, busy_o}, {7'd0, exp_busy});
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] ALU = 2'd0, MEM = 2'd1, MUL = 2'd2;

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        slot(0, 5'd0, 5'd0, 5'd0, ALU, 1'b0);
        slot(1, 5'd0, 5'd0, 5'd0, ALU, 1'b0);
        step("reset", 2'b00, 1'b0);
        rst_n = 1'b1;

        // Basic pair issue, then scoreboard blocks and bypass
        idle(); slot(0, 5'd1, 5'd2, 5'd3, ALU, 1'b0); slot(1, 5'd4, 5'd0, 5'd5, ALU, 1'b0);
        step("pair_alu", 2'b11, 1'b0);
        idle(); slot(0, 5'd3, 5'd0, 5'd0, ALU, 1'b0);
        step("raw_r3", 2'b00, 1'b1);
        idle(); slot(0, 5'd0, 5'd5, 5'd0, ALU, 1'b0);
        step("raw_r5", 2'b00, 1'b1);
        idle(); slot(0, 5'd3, 5'd0, 5'd0, ALU, 1'b0); wb(0, 5'd3);
        step("bypass_p0", 2'b01, 1'b1);
        idle(); slot(0, 5'd5, 5'd0, 5'd0, ALU, 1'b0); wb(1, 5'd5);
        step("bypass_p1", 2'b01, 1'b1);
        idle();
        step("drained", 2'b00, 1'b0);

        // Intra-pair hazards and pipe conflicts
        idle(); slot(0, 5'd0, 5'd0, 5'd7, ALU, 1'b0); slot(1, 5'd0, 5'd7, 5'd0, ALU, 1'b0);
        step("intra_raw", 2'b01, 1'b0);
        idle(); wb(0, 5'd7);
        step("clr7", 2'b00, 1'b1);
        idle(); slot(0, 5'd1, 5'd0, 5'd8, MEM, 1'b0); slot(1, 5'd2, 5'd0, 5'd10, MEM, 1'b0);
        step("mem_mem", 2'b01, 1'b0);
        idle(); slot(0, 5'd1, 5'd0, 5'd0, MEM, 1'b0); slot(1, 5'd2, 5'd0, 5'd0, ALU, 1'b0); wb(1, 5'd8);
        step("mem_alu", 2'b11, 1'b1);
        idle(); slot(0, 5'd0, 5'd0, 5'd0, MUL, 1'b0); slot(1, 5'd0, 5'd0, 5'd0, MUL, 1'b0);
        step("mul_mul", 2'b01, 1'b0);

        // WAW blocks and set-over-clear
        idle(); slot(0, 5'd0, 5'd0, 5'd6, ALU, 1'b0); slot(1, 5'd0, 5'd0, 5'd6, ALU, 1'b0);
        step("intra_waw", 2'b01, 1'b0);
        idle(); slot(0, 5'd0, 5'd0, 5'd6, ALU, 1'b0);
        step("waw_pend", 2'b00, 1'b1);
        idle(); slot(0, 5'd0, 5'd0, 5'd6, ALU, 1'b0); wb(0, 5'd6);
        step("waw_bypass", 2'b01, 1'b1);
        idle(); slot(0, 5'd6, 5'd0, 5'd0, ALU, 1'b0);
        step("set_wins", 2'b00, 1'b1);
        idle(); wb(0, 5'd6);
        step("clr6", 2'b00, 1'b1);

        // Serializing instruction waits for empty scoreboard, then blocks until done
        idle(); slot(0, 5'd0, 5'd0, 5'd9, ALU, 1'b0);
        step("set9", 2'b01, 1'b0);
        idle(); slot(0, 5'd0, 5'd0, 5'd0, ALU, 1'b1); slot(1, 5'd1, 5'd0, 5'd0, ALU, 1'b0);
        step("csr_wait", 2'b00, 1'b1);
        idle(); slot(0, 5'd0, 5'd0, 5'd0, ALU, 1'b1); slot(1, 5'd1, 5'd0, 5'd0, ALU, 1'b0); wb(0, 5'd9);
        step("csr_go", 2'b01, 1'b1);
        idle(); slot(0, 5'd1, 5'd0, 5'd0, ALU, 1'b0); slot(1, 5'd2, 5'd0, 5'd0, ALU, 1'b0);
        step("serial_hold", 2'b00, 1'b1);
        idle(); slot(0, 5'd1, 5'd0, 5'd0, ALU, 1'b0); slot(1, 5'd2, 5'd0, 5'd0, ALU, 1'b0);
        serial_done_i = 1'b1;
        step("serial_done", 2'b00, 1'b1);
        idle(); slot(0, 5'd1, 5'd0, 5'd0, ALU, 1'b0); slot(1, 5'd2, 5'd0, 5'd0, ALU, 1'b0);
        step("serial_resume", 2'b11, 1'b0);

        // Flush kills pending writes and leaves SERIAL
        idle(); slot(0, 5'd0, 5'd0, 5'd12, ALU, 1'b0);
        step("set12", 2'b01, 1'b0);
        idle(); slot(0, 5'd0, 5'd0, 5'd13, ALU, 1'b0); flush_i = 1'b1;
        step("flush_blk", 2'b00, 1'b1);
        idle(); slot(0, 5'd12, 5'd13, 5'd0, ALU, 1'b0);
        step("post_flush", 2'b01, 1'b0);
        idle(); slot(0, 5'd0, 5'd0, 5'd0, ALU, 1'b1);
        step("serial2", 2'b01, 1'b0);
        idle(); slot(0, 5'd0, 5'd0, 5'd0, ALU, 1'b0); flush_i = 1'b1;
        step("flush_serial", 2'b00, 1'b1);
        idle(); slot(0, 5'd0, 5'd0, 5'd0, ALU, 1'b0);
        step("flush_resume", 2'b01, 1'b0);

        // serial_done in NORMAL is ignored; stall blocks
        idle(); slot(0, 5'd0, 5'd0, 5'd14, ALU, 1'b0); serial_done_i = 1'b1;
        step("done_normal", 2'b01, 1'b0);
        idle(); slot(0, 5'd0, 5'd0, 5'd0, ALU, 1'b0); backend_stall_i = 1'b1;
        step("stall", 2'b00, 1'b1);
        idle(); wb(0, 5'd14); wb(1, 5'd14);
        step("dual_wb", 2'b00, 1'b1);

        // Asynchronous reset while in SERIAL
        idle(); slot(0, 5'd0, 5'd0, 5'd15, ALU, 1'b1);
        step("serial3", 2'b01, 1'b0);
        idle(); slot(0, 5'd0, 5'd0, 5'd0, ALU, 1'b0); slot(1, 5'd0, 5'd0, 5'd0, ALU, 1'b0);
        #1 rst_n = 1'b0;
        step("async_rst", 2'b00, 1'b0);
        rst_n = 1'b1;
        idle(); slot(0, 5'd15, 5'd0, 5'd0, ALU, 1'b0); slot(1, 5'd0, 5'd0, 5'd0, ALU, 1'b0);
        step("after_rst", 2'b11, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
